can_rx_frame_decoder: RTL and testbench
=======================================

Name: can_rx_frame_decoder

Overview:
- Receive-side stage directly downstream of the CAN node's bus interface.
- Consumes one sampled bus bit per enabled `can_clk` cycle and finds SOF.
- Removes stuff bits, computes and checks CRC-15, and extracts ID, RTR, DLC and data.
- Presents each completed standard-format frame to the node's PROCESS logic as a one-cycle valid pulse with held fields; reports stuff, CRC and form errors.

Parameters:
- MAX_BYTES, 8, maximum data bytes stored; DLC values above 8 are clamped to 8.
- IDLE_BITS, 11, consecutive recessive bits required to leave ERROR.

Ports:
- can_clk  in  1  bit clock.
- reset  in  1  synchronous, active-high.
- bit_en  in  1  rx_bit is valid this cycle; all state advances only when it is high.
- rx_bit  in  1  logical bus level, 0=dominant, 1=recessive.
- busy  out  1  high while in any state other than IDLE.
- frame_valid  out  1  one-cycle pulse when a frame is accepted.
- frame_id  out  11  identifier, MSB first on the bus.
- frame_rtr  out  1  RTR bit.
- frame_dlc  out  4  raw DLC as received.
- frame_data  out  64  first byte in [63:56]; unused bytes are 0.
- stuff_err  out  1  one-cycle pulse.
- crc_err  out  1  one-cycle pulse.
- form_err  out  1  one-cycle pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, CRC register 0, stuff counter 0.
- Reset asserted mid-frame aborts the frame immediately with no error pulse.
- Sampling: bits are sampled on `can_clk` rising edge only when `bit_en`=1; cycles with `bit_en`=0 change nothing except clearing the output pulses.
- States and transitions:
  - IDLE → ARB on rx_bit=0 (SOF). SOF is fed to the CRC and starts a stuff run of 1.
  - ARB: 11 ID bits, then RTR → CTRL.
  - CTRL: IDE, r0, DLC[3:0]. IDE=1 → form_err, then ERROR (extended format unsupported).
  - CTRL exit:
    - RTR=1 or DLC=0 → CRC.
    - otherwise → DATA with 8*min(DLC,8) bits.
  - DATA: shift bits MSB first into byte slots starting at [63:56] → CRC.
  - CRC: 15 bits → CRC_DEL.
  - CRC_DEL: must be 1, else form_err → ERROR.
  - ACK: slot (value ignored) and delimiter (must be 1, else form_err → ERROR) → EOF.
  - EOF: 7 bits, all must be 1; a 0 gives form_err → ERROR.
  - ERROR: count consecutive 1s; any 0 restarts the count; at IDLE_BITS go to IDLE.
- Frame completion: on the 7th EOF bit, frame_valid=1 for one cycle, state goes to IDLE.
  - Fields are latched into the outputs on that same edge and held until the next frame_valid.
  - A failed frame never updates the held fields.
- Destuffing window: SOF through the last CRC bit.
  - After 5 consecutive equal bits, the next bit is a stuff bit. It must be the opposite level; it is discarded and starts a new run of 1.
  - A stuff bit equal to the run → stuff_err → ERROR.
  - No destuffing from CRC_DEL onward.
- CRC-15 rule, per destuffed bit from SOF through the last data bit:
  - nxt = bit ^ crc[14]
  - crc = {crc[13:0],1'b0}
  - if nxt, crc = crc ^ 15'h4599
- CRC check: the received 15-bit CRC is compared at the end of the CRC field. A mismatch raises crc_err at the CRC_DEL bit, and the decoder goes to ERROR without checking the delimiter.
- Error priority: stuff_err is evaluated before field decoding. At most one error pulse is raised per frame.
- DLC boundaries: DLC 9–15 receives 8 bytes and frame_dlc reports the raw value.
- Latency: frame_valid asserts on the edge that samples the last EOF bit, i.e. 0 extra cycles.

Decomposition:
- Shared package can_pkg holds:
  - state enum: IDLE, ARB, CTRL, DATA, CRC, CRC_DEL, ACK, EOF, ERROR.
  - CRC15_POLY=15'h4599.
  - ID_BITS=11, EOF_BITS=7, STUFF_LIMIT=5.
- One sub-module, can_crc15: clear, bit_en, data bit in, 15-bit crc out. The transmitter reuses it.

Test Plan:
- Frame ID 0x123, RTR 0, DLC 1, data 0x89, CRC from the bench model, stuffed, all EOF 1 → frame_valid pulse; frame_id=0x123, frame_dlc=1, frame_data=64'h8900000000000000; no error pulses.
- ID 0x000 (forces stuffing inside the ID), DLC 0 → frame_valid, frame_id=0x000, frame_data=0. Repeat with one stuff bit inverted → stuff_err pulse, no frame_valid, fields unchanged.
- ID 0x456, DLC 2, data 0xAA55, last CRC bit flipped → crc_err at CRC_DEL, ERROR state; then 11 recessive bits → IDLE, busy=0.
- DLC=12 with 8 data bytes 0x0102030405060708 → frame_dlc=12, frame_data=64'h0102030405060708. Same frame with EOF bit 4 = 0 → form_err.
- Toggle bit_en randomly low during a valid frame → identical outputs. Assert reset during the DATA field → all outputs 0, IDLE, no error pulse.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN definitions: receive FSM states, frame field sizes and the CRC-15 step.
package can_pkg;

  typedef enum logic [3:0] {
    StIdle, StArb, StCtrl, StData, StCrc, StCrcDel, StAck, StEof, StError
  } can_state_e;

  localparam logic [14:0] CRC15_POLY  = 15'h4599;
  localparam int unsigned ID_BITS     = 11;
  localparam int unsigned EOF_BITS    = 7;
  localparam int unsigned STUFF_LIMIT = 5;
  localparam int unsigned CRC_BITS    = 15;

  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    logic [14:0] nxt;
    nxt = {crc[13:0], 1'b0};
    if (b ^ crc[14]) nxt = nxt ^ CRC15_POLY;
    return nxt;
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CRC-15 accumulator; clear and a feed on the same cycle restart from zero with that bit.
module can_crc15
  import can_pkg::*;
(
  input  logic        can_clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        bit_en,
  input  logic        data_bit,
  output logic [14:0] crc
);

  logic [14:0] crc_q, crc_d, base;

  always_comb begin
    base  = clear ? '0 : crc_q;
    crc_d = bit_en ? crc15_step(base, data_bit) : base;
  end

  always_ff @(posedge can_clk) begin
    if (reset) crc_q <= '0;
    else       crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/can_rx_frame_decoder.sv
// Standard-format CAN receive decoder: destuffs, checks CRC-15 and framing, presents held fields.
module can_rx_frame_decoder
  import can_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned IDLE_BITS = 11
) (
  input  logic                   can_clk,
  input  logic                   reset,
  input  logic                   bit_en,
  input  logic                   rx_bit,
  output logic                   busy,
  output logic                   frame_valid,
  output logic [10:0]            frame_id,
  output logic                   frame_rtr,
  output logic [3:0]             frame_dlc,
  output logic [8*MAX_BYTES-1:0] frame_data,
  output logic                   stuff_err,
  output logic                   crc_err,
  output logic                   form_err
);

  localparam int unsigned DataW = 8 * MAX_BYTES;
  localparam int unsigned IdxW  = $clog2(DataW);
  localparam int unsigned CntW  = 8;

  localparam logic [CntW-1:0] RtrCnt   = CntW'(ID_BITS);
  localparam logic [CntW-1:0] DlcLast  = CntW'(5);
  localparam logic [CntW-1:0] CrcLast  = CntW'(CRC_BITS - 1);
  localparam logic [CntW-1:0] EofLast  = CntW'(EOF_BITS - 1);
  localparam logic [CntW-1:0] IdleLast = CntW'(IDLE_BITS - 1);
  localparam logic [2:0]      StuffLim = 3'(STUFF_LIMIT);
  localparam logic [3:0]      MaxBytes = 4'(MAX_BYTES);

  can_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, data_bits_q, data_bits_d;
  logic [2:0]        run_q, run_d;
  logic              last_q, last_d;
  logic [10:0]       id_q, id_d;
  logic              rtr_q, rtr_d;
  logic [3:0]        dlc_q, dlc_d;
  logic [DataW-1:0]  data_q, data_d;
  logic [14:0]       crc_rx_q, crc_rx_d;

  logic              valid_q, valid_d, stuff_err_q, stuff_err_d;
  logic              crc_err_q, crc_err_d, form_err_q, form_err_d;
  logic [10:0]       fid_q, fid_d;
  logic              frtr_q, frtr_d;
  logic [3:0]        fdlc_q, fdlc_d;
  logic [DataW-1:0]  fdata_q, fdata_d;

  logic              crc_clear, crc_feed, stuff_bit, in_window;
  logic [14:0]       crc_calc;
  logic [IdxW-1:0]   data_idx;
  logic [3:0]        nbytes;

  can_crc15 u_crc (
    .can_clk  (can_clk),
    .reset    (reset),
    .clear    (crc_clear),
    .bit_en   (crc_feed),
    .data_bit (rx_bit),
    .crc      (crc_calc)
  );

  assign data_idx  = IdxW'(DataW - 1) - IdxW'(cnt_q);
  assign in_window = (state_q == StArb) || (state_q == StCtrl) ||
                     (state_q == StData) || (state_q == StCrc);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_bits_d = data_bits_q;
    run_d       = run_q;
    last_d      = last_q;
    id_d        = id_q;
    rtr_d       = rtr_q;
    dlc_d       = dlc_q;
    data_d      = data_q;
    crc_rx_d    = crc_rx_q;
    fid_d       = fid_q;
    frtr_d      = frtr_q;
    fdlc_d      = fdlc_q;
    fdata_d     = fdata_q;
    valid_d     = 1'b0;
    stuff_err_d = 1'b0;
    crc_err_d   = 1'b0;
    form_err_d  = 1'b0;
    crc_clear   = 1'b0;
    crc_feed    = 1'b0;
    stuff_bit   = 1'b0;
    nbytes      = '0;

    if (bit_en) begin
      // Stuff tracking runs ahead of field decoding so a bad stuff bit wins over any field error.
      if (in_window) begin
        if (run_q == StuffLim) begin
          stuff_bit = 1'b1;
          if (rx_bit == last_q) begin
            stuff_err_d = 1'b1;
            state_d     = StError;
            cnt_d       = '0;
          end else begin
            last_d = rx_bit;
            run_d  = 3'd1;
          end
        end else if (rx_bit == last_q) begin
          run_d = run_q + 3'd1;
        end else begin
          run_d  = 3'd1;
          last_d = rx_bit;
        end
      end

      if (!stuff_bit) begin
        unique case (state_q)
          StIdle: begin
            if (!rx_bit) begin
              state_d   = StArb;
              cnt_d     = '0;
              run_d     = 3'd1;
              last_d    = 1'b0;
              crc_clear = 1'b1;
              crc_feed  = 1'b1;
              id_d      = '0;
              rtr_d     = 1'b0;
              dlc_d     = '0;
              data_d    = '0;
              crc_rx_d  = '0;
            end
          end
          StArb: begin
            crc_feed = 1'b1;
            if (cnt_q < RtrCnt) begin
              id_d  = {id_q[9:0], rx_bit};
              cnt_d = cnt_q + 1'b1;
            end else begin
              rtr_d   = rx_bit;
              state_d = StCtrl;
              cnt_d   = '0;
            end
          end
          StCtrl: begin
            crc_feed = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == '0 && rx_bit) begin
              form_err_d = 1'b1;
              state_d    = StError;
              cnt_d      = '0;
            end else if (cnt_q >= CntW'(2)) begin
              dlc_d = {dlc_q[2:0], rx_bit};
              if (cnt_q == DlcLast) begin
                nbytes      = (dlc_d > MaxBytes) ? MaxBytes : dlc_d;
                data_bits_d = {1'b0, nbytes, 3'b000};
                cnt_d       = '0;
                state_d     = (rtr_q || dlc_d == 4'd0) ? StCrc : StData;
              end
            end
          end
          StData: begin
            crc_feed         = 1'b1;
            data_d[data_idx] = rx_bit;
            cnt_d            = cnt_q + 1'b1;
            if (cnt_q == data_bits_q - 1'b1) begin
              state_d = StCrc;
              cnt_d   = '0;
            end
          end
          StCrc: begin
            crc_rx_d = {crc_rx_q[13:0], rx_bit};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CrcLast) begin
              state_d = StCrcDel;
              cnt_d   = '0;
            end
          end
          StCrcDel: begin
            state_d = StAck;
            if (crc_rx_q != crc_calc) begin
              crc_err_d = 1'b1;
              state_d   = StError;
            end else if (!rx_bit) begin
              form_err_d = 1'b1;
              state_d    = StError;
            end
          end
          StAck: begin
            if (cnt_q == '0) begin
              cnt_d = CntW'(1);
            end else if (!rx_bit) begin
              form_err_d = 1'b1;
              state_d    = StError;
              cnt_d      = '0;
            end else begin
              state_d = StEof;
              cnt_d   = '0;
            end
          end
          StEof: begin
            if (!rx_bit) begin
              form_err_d = 1'b1;
              state_d    = StError;
              cnt_d      = '0;
            end else if (cnt_q == EofLast) begin
              valid_d = 1'b1;
              fid_d   = id_q;
              frtr_d  = rtr_q;
              fdlc_d  = dlc_q;
              fdata_d = data_q;
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          StError: begin
            if (!rx_bit) begin
              cnt_d = '0;
            end else if (cnt_q == IdleLast) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge can_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      data_bits_q <= '0;
      run_q       <= '0;
      last_q      <= 1'b0;
      id_q        <= '0;
      rtr_q       <= 1'b0;
      dlc_q       <= '0;
      data_q      <= '0;
      crc_rx_q    <= '0;
      valid_q     <= 1'b0;
      stuff_err_q <= 1'b0;
      crc_err_q   <= 1'b0;
      form_err_q  <= 1'b0;
      fid_q       <= '0;
      frtr_q      <= 1'b0;
      fdlc_q      <= '0;
      fdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_bits_q <= data_bits_d;
      run_q       <= run_d;
      last_q      <= last_d;
      id_q        <= id_d;
      rtr_q       <= rtr_d;
      dlc_q       <= dlc_d;
      data_q      <= data_d;
      crc_rx_q    <= crc_rx_d;
      valid_q     <= valid_d;
      stuff_err_q <= stuff_err_d;
      crc_err_q   <= crc_err_d;
      form_err_q  <= form_err_d;
      fid_q       <= fid_d;
      frtr_q      <= frtr_d;
      fdlc_q      <= fdlc_d;
      fdata_q     <= fdata_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign frame_valid = valid_q;
  assign frame_id    = fid_q;
  assign frame_rtr   = frtr_q;
  assign frame_dlc   = fdlc_q;
  assign frame_data  = fdata_q;
  assign stuff_err   = stuff_err_q;
  assign crc_err     = crc_err_q;
  assign form_err    = form_err_q;

endmodule

// File: tb/tb_can_rx_frame_decoder.sv
// Bench: builds bit-level CAN frames from field values, stuffs them and checks the decoder.
module tb_can_rx_frame_decoder;

  logic        can_clk = 1'b0;
  logic        reset, bit_en, rx_bit;
  logic        busy, frame_valid, frame_rtr, stuff_err, crc_err, form_err;
  logic [10:0] frame_id;
  logic [3:0]  frame_dlc;
  logic [63:0] frame_data;

  can_rx_frame_decoder dut (
    .can_clk     (can_clk),
    .reset       (reset),
    .bit_en      (bit_en),
    .rx_bit      (rx_bit),
    .busy        (busy),
    .frame_valid (frame_valid),
    .frame_id    (frame_id),
    .frame_rtr   (frame_rtr),
    .frame_dlc   (frame_dlc),
    .frame_data  (frame_data),
    .stuff_err   (stuff_err),
    .crc_err     (crc_err),
    .form_err    (form_err)
  );

  always #5 can_clk = ~can_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference frame image
  bit          raw[$];
  bit          tx[$];
  int          stuff_pos[$];
  int          raw_pos[$];
  int          crc_del_idx, last_eof_idx;
  logic [63:0] exp_data;

  // Observations from the last send
  int n_valid, n_stuff, n_crc, n_form, valid_idx, err_idx;
  bit busy_at_err;

  // CRC as the remainder of M(x)*x^15 divided by x^15 + 0x4599, by long division.
  function automatic logic [14:0] ref_crc();
    bit          m[$];
    logic [15:0] g;
    logic [14:0] r;
    g = 16'hC599;
    m = raw;
    for (int i = 0; i < 15; i++) m.push_back(1'b0);
    for (int i = 0; i < raw.size(); i++)
      if (m[i]) for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ g[15-j];
    for (int i = 0; i < 15; i++) r[14-i] = m[raw.size()+i];
    return r;
  endfunction

  task automatic build_frame(input logic [10:0] id, input bit rtr, input logic [3:0] dlc,
                             input logic [63:0] data);
    int          nbytes, run, wl;
    bit          last;
    logic [14:0] crc;
    raw.delete(); tx.delete(); stuff_pos.delete(); raw_pos.delete();
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr); raw.push_back(1'b0); raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nbytes   = rtr ? 0 : ((dlc > 8) ? 8 : int'(dlc));
    exp_data = '0;
    for (int i = 0; i < nbytes * 8; i++) begin
      raw.push_back(data[63-i]);
      exp_data[63-i] = data[63-i];
    end
    crc = ref_crc();
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    wl = raw.size();
    run = 0; last = 1'b0;
    for (int i = 0; i < wl; i++) begin
      raw_pos.push_back(tx.size());
      tx.push_back(raw[i]);
      if (i == 0 || raw[i] != last) run = 1; else run++;
      last = raw[i];
      if (run == 5 && i < wl - 1) begin
        stuff_pos.push_back(tx.size());
        tx.push_back(!last);
        last = !last;
        run = 1;
      end
    end
    crc_del_idx = tx.size();
    tx.push_back(1'b1);                        // CRC delimiter
    tx.push_back(1'b0);                        // ACK slot
    tx.push_back(1'b1);                        // ACK delimiter
    for (int i = 0; i < 7; i++) tx.push_back(1'b1);
    last_eof_idx = tx.size() - 1;
    for (int i = 0; i < 12; i++) tx.push_back(1'b1);
  endtask

  task automatic sample(input int idx);
    if (frame_valid) begin n_valid++; valid_idx = idx; end
    if (stuff_err)   begin n_stuff++; err_idx = idx; busy_at_err = busy; end
    if (crc_err)     begin n_crc++;   err_idx = idx; busy_at_err = busy; end
    if (form_err)    begin n_form++;  err_idx = idx; busy_at_err = busy; end
  endtask

  task automatic send(input int upto, input bit gaps);
    n_valid = 0; n_stuff = 0; n_crc = 0; n_form = 0;
    valid_idx = -1; err_idx = -1; busy_at_err = 1'b0;
    for (int i = 0; i < upto; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(negedge can_clk); bit_en = 1'b0; rx_bit = 1'($urandom_range(0, 1));
        @(posedge can_clk); #1; sample(-1);
      end
      @(negedge can_clk); bit_en = 1'b1; rx_bit = tx[i];
      @(posedge can_clk); #1; sample(i);
    end
    @(negedge can_clk); bit_en = 1'b0; rx_bit = 1'b1;
  endtask

  task automatic check_good(input string t, input logic [10:0] id, input bit rtr,
                            input logic [3:0] dlc);
    check_eq({t, " valid_cnt"}, 64'(n_valid), 64'd1);
    check_eq({t, " valid_at"},  64'(valid_idx), 64'(last_eof_idx));
    check_eq({t, " id"},        64'(frame_id), 64'(id));
    check_eq({t, " rtr"},       64'(frame_rtr), 64'(rtr));
    check_eq({t, " dlc"},       64'(frame_dlc), 64'(dlc));
    check_eq({t, " data"},      frame_data, exp_data);
    check_eq({t, " errs"},      64'(n_stuff + n_crc + n_form), 64'd0);
    check_eq({t, " busy"},      64'(busy), 64'd0);
  endtask

  logic [10:0] r_id;
  bit          r_rtr;
  logic [3:0]  r_dlc;
  logic [63:0] r_data;

  initial begin
    reset = 1'b1; bit_en = 1'b0; rx_bit = 1'b1;
    repeat (3) @(posedge can_clk);
    #1;
    check_eq("rst busy",  64'(busy), 64'd0);
    check_eq("rst valid", 64'(frame_valid), 64'd0);
    check_eq("rst id",    64'(frame_id), 64'd0);
    check_eq("rst data",  frame_data, 64'd0);
    check_eq("rst errs",  64'({stuff_err, crc_err, form_err}), 64'd0);
    @(negedge can_clk); reset = 1'b0;

    build_frame(11'h123, 1'b0, 4'd1, 64'h8900_0000_0000_0000);
    send(tx.size(), 1'b0);
    check_good("f123", 11'h123, 1'b0, 4'd1);
    check_eq("f123 data_lit", frame_data, 64'h8900_0000_0000_0000);

    build_frame(11'h000, 1'b0, 4'd0, 64'd0);
    check_eq("f000 has_stuff", 64'(stuff_pos.size() > 0), 64'd1);
    send(tx.size(), 1'b0);
    check_good("f000", 11'h000, 1'b0, 4'd0);

    build_frame(11'h5A3, 1'b0, 4'd12, 64'h0102_0304_0506_0708);
    send(tx.size(), 1'b0);
    check_good("dlc12", 11'h5A3, 1'b0, 4'd12);

    // Bad stuff bit: error at that bit, held fields stay from the previous frame.
    build_frame(11'h000, 1'b0, 4'd0, 64'd0);
    tx[stuff_pos[0]] = !tx[stuff_pos[0]];
    send(tx.size(), 1'b0);
    check_eq("stuff cnt",   64'(n_stuff), 64'd1);
    check_eq("stuff at",    64'(err_idx), 64'(stuff_pos[0]));
    check_eq("stuff other", 64'(n_valid + n_crc + n_form), 64'd0);
    check_eq("stuff id",    64'(frame_id), 64'h5A3);
    check_eq("stuff data",  frame_data, 64'h0102_0304_0506_0708);
    check_eq("stuff busy",  64'(busy), 64'd0);

    build_frame(11'h456, 1'b0, 4'd2, 64'hAA55_0000_0000_0000);
    tx[crc_del_idx-1] = !tx[crc_del_idx-1];
    send(tx.size(), 1'b0);
    check_eq("crc cnt",   64'(n_crc), 64'd1);
    check_eq("crc at",    64'(err_idx), 64'(crc_del_idx));
    check_eq("crc inerr", 64'(busy_at_err), 64'd1);
    check_eq("crc other", 64'(n_valid + n_stuff + n_form), 64'd0);
    check_eq("crc idle",  64'(busy), 64'd0);
    check_eq("crc dlc",   64'(frame_dlc), 64'd12);

    build_frame(11'h5A3, 1'b0, 4'd12, 64'h0102_0304_0506_0708);
    tx[last_eof_idx-3] = 1'b0;
    send(tx.size(), 1'b0);
    check_eq("eof cnt",   64'(n_form), 64'd1);
    check_eq("eof at",    64'(err_idx), 64'(last_eof_idx - 3));
    check_eq("eof other", 64'(n_valid + n_stuff + n_crc), 64'd0);
    check_eq("eof idle",  64'(busy), 64'd0);

    build_frame(11'h123, 1'b0, 4'd1, 64'h8900_0000_0000_0000);
    send(tx.size(), 1'b1);
    check_good("gap123", 11'h123, 1'b0, 4'd1);

    for (int k = 0; k < 6; k++) begin
      r_id   = 11'($urandom);
      r_rtr  = (k == 2);
      r_dlc  = 4'($urandom_range(0, 15));
      r_data = {32'($urandom), 32'($urandom)};
      build_frame(r_id, r_rtr, r_dlc, r_data);
      send(tx.size(), 1'b1);
      check_good($sformatf("rnd%0d", k), r_id, r_rtr, r_dlc);
    end

    // Reset in the middle of the data field.
    build_frame(11'h2A5, 1'b0, 4'd8, 64'hDEAD_BEEF_0123_4567);
    send(raw_pos[29] + 1, 1'b0);
    check_eq("mid busy", 64'(busy), 64'd1);
    @(negedge can_clk); reset = 1'b1;
    @(posedge can_clk); #1;
    check_eq("mid errs",  64'(n_stuff + n_crc + n_form + n_valid), 64'd0);
    check_eq("mrst busy", 64'(busy), 64'd0);
    check_eq("mrst flds", 64'({frame_id, frame_rtr, frame_dlc}), 64'd0);
    check_eq("mrst data", frame_data, 64'd0);
    check_eq("mrst puls", 64'({frame_valid, stuff_err, crc_err, form_err}), 64'd0);
    @(negedge can_clk); reset = 1'b0;
    send(tx.size(), 1'b0);
    check_good("after_rst", 11'h2A5, 1'b0, 4'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
